// File: rtl/fifo_boot_loader.sv
// fifo_boot_loader: drains a framed boot image from the receive FIFO into
// instruction RAM. The image is a header word (magic + length), then N payload
// words, then a 32-bit additive checksum. The CPU is held in reset until the
// checksum matches.
module fifo_boot_loader #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      boot_clk_i,
    input  logic                      boot_rst_i,
    input  logic                      boot_start_i,
    input  logic                      boot_fifo_empty_i,
    input  logic [31:0]               boot_fifo_data_i,
    output logic                      boot_fifo_rd_o,
    output logic                      boot_mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] boot_mem_addr_o,
    output logic [31:0]               boot_mem_data_o,
    output logic                      boot_cpu_rst_o,
    output logic                      boot_busy_o,
    output logic                      boot_done_o,
    output logic                      boot_error_o,
    output logic [2:0]                boot_error_code_o
);

    // The word counter is one bit wider than the address so that a full-memory
    // image (N == 2^MEM_ADDR_WIDTH) can be counted to completion.
    localparam int CNT_W = MEM_ADDR_WIDTH + 1;
    // The timeout counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [15:0]     MAGIC     = 16'hB007;
    localparam logic [32:0]     MAX_WORDS = 33'(1) << MEM_ADDR_WIDTH;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MAGIC    = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                code_q, code_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_cnt_q;
    logic [CNT_W-1:0]          word_cnt_q;
    logic [CNT_W-1:0]          len_q;
    logic [31:0]               sum_q;
    logic [TO_W-1:0]           to_cnt_q;

    logic        active;
    logic        pop;
    logic        restart;
    logic        timed_out;
    logic        last_word;
    logic [32:0] hdr_len;
    logic        magic_bad;
    logic        len_bad;

    // Header decode is done straight off the FIFO head; it only matters on the
    // cycle the header is actually popped.
    assign hdr_len   = {17'd0, boot_fifo_data_i[15:0]};
    assign magic_bad = boot_fifo_data_i[31:16] != MAGIC;
    assign len_bad   = (hdr_len == 33'd0) || (hdr_len > MAX_WORDS);
    assign last_word = (word_cnt_q + CNT_W'(1)) == len_q;

    // Pop decision, timeout detection and next-state selection.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        restart   = 1'b0;
        active    = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_CHECK);
        pop       = active && !boot_fifo_empty_i;
        // A pop on the limit cycle clears the counter instead, so the pop wins.
        timed_out = active && !pop && (to_cnt_q == TO_LAST);

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (boot_start_i) begin
                    state_d = S_HEADER;
                    code_d  = ERR_NONE;
                    restart = 1'b1;
                end
            end
            S_HEADER: begin
                if (pop) begin
                    if (magic_bad) begin
                        state_d = S_ERROR;
                        code_d  = ERR_MAGIC;
                    end else if (len_bad) begin
                        state_d = S_ERROR;
                        code_d  = ERR_LENGTH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pop && last_word) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (pop) begin
                    if (boot_fifo_data_i == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        code_d  = ERR_CHECKSUM;
                    end
                end
            end
            S_DONE: begin
                // Terminal until reset; start is deliberately ignored here.
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed_out) begin
            state_d = S_ERROR;
            code_d  = ERR_TIMEOUT;
        end
    end

    // State and error code registers.
    always_ff @(posedge boot_clk_i or posedge boot_rst_i) begin
        if (boot_rst_i) begin
            state_q <= S_IDLE;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Load counters, latched length and running checksum.
    always_ff @(posedge boot_clk_i or posedge boot_rst_i) begin
        if (boot_rst_i) begin
            addr_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            sum_q      <= '0;
        end else if (restart) begin
            addr_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            sum_q      <= '0;
        end else begin
            if (state_q == S_HEADER && pop) begin
                len_q <= CNT_W'(hdr_len);
            end
            if (state_q == S_LOAD && pop) begin
                // addr_cnt wraps to 0 after a full-memory image; never used again.
                addr_cnt_q <= addr_cnt_q + MEM_ADDR_WIDTH'(1);
                word_cnt_q <= word_cnt_q + CNT_W'(1);
                sum_q      <= sum_q + boot_fifo_data_i;
            end
        end
    end

    // Consecutive no-pop cycles while loading; cleared by every pop.
    always_ff @(posedge boot_clk_i or posedge boot_rst_i) begin
        if (boot_rst_i) begin
            to_cnt_q <= '0;
        end else if (restart) begin
            to_cnt_q <= '0;
        end else if (active) begin
            to_cnt_q <= pop ? '0 : to_cnt_q + TO_W'(1);
        end
    end

    // Registered RAM write port: one strobe per payload pop, one cycle later.
    always_ff @(posedge boot_clk_i or posedge boot_rst_i) begin
        if (boot_rst_i) begin
            boot_mem_we_o   <= 1'b0;
            boot_mem_addr_o <= '0;
            boot_mem_data_o <= '0;
        end else begin
            boot_mem_we_o <= (state_q == S_LOAD) && pop;
            if (state_q == S_LOAD && pop) begin
                boot_mem_addr_o <= addr_cnt_q;
                boot_mem_data_o <= boot_fifo_data_i;
            end
        end
    end

    assign boot_fifo_rd_o    = pop;
    assign boot_busy_o       = active;
    assign boot_done_o       = state_q == S_DONE;
    assign boot_error_o      = state_q == S_ERROR;
    assign boot_cpu_rst_o    = state_q != S_DONE;
    assign boot_error_code_o = code_q;

endmodule
